dmem_responder: RTL and testbench

- Data-memory responder: the target end of the processor's load/store interface. The datapath drives the address, store data and write strobe; this block answers with load data.
- Holds a word-organised RAM, applies a programmable number of wait states, and signals completion with a one-cycle ready pulse plus an error flag.
- Sits between the datapath's memory port and the rest of the system. It is the slave for the upcoming multicycle core and for bench stress of wait-state tolerance.

---
 rtl/dmem_responder.sv | 165 ++++++++++++++++
 tb/tb_dmem_responder.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder
//   Target end of the processor load/store port. Holds a word-organised RAM,
//   inserts LATENCY wait cycles per access and answers with a one-cycle
//   ready pulse carrying load data and an error flag.
//
//   Optional feature macro: DMEM_BYTE_LANE_EN
//     defined   -> be[3:0] port exists; legal stores write only enabled lanes
//     undefined -> no be port; legal stores write the full word
//
// Ports:
//   clk    in   1   system clock, rising edge
//   reset  in   1   synchronous active-low reset
//   req    in   1   access request, sampled only in IDLE
//   we     in   1   1 = store, 0 = load (captured with req)
//   addr   in   32  byte address (captured with req)
//   wdata  in   32  store data (captured with req)
//   be     in   4   byte-lane enables (DMEM_BYTE_LANE_EN only)
//   rdata  out  32  load data, valid while ready=1
//   ready  out  1   one-cycle completion pulse
//   err    out  1   access error, valid while ready=1
module dmem_responder #(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
`ifdef DMEM_BYTE_LANE_EN
    input  logic [3:0]  be,
`endif
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          we_q, we_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] idx;
    logic          acc_err;
    logic          mem_wr;
    logic [3:0]    lane_en;

`ifdef DMEM_BYTE_LANE_EN
    logic [3:0]    be_q, be_d;
    assign lane_en = be_q;
`else
    assign lane_en = 4'hF;
`endif

    assign idx     = addr_q[AW+1:2];
    // Upper address bits must all be zero: out-of-range addresses never alias.
    assign acc_err = (addr_q[1:0] != 2'b00) || (addr_q[31:AW+2] != '0);

    assign ready = (state_q == DONE);
    assign rdata = rdata_q;
    assign err   = err_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        mem_wr  = 1'b0;
`ifdef DMEM_BYTE_LANE_EN
        be_d    = be_q;
`endif
        case (state_q)
            IDLE: begin
                if (req) begin
                    we_d    = we;
                    addr_d  = addr;
                    wdata_d = wdata;
`ifdef DMEM_BYTE_LANE_EN
                    be_d    = be;
`endif
                    cnt_d   = 4'(LATENCY);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = DONE;
                    if (acc_err) begin
                        rdata_d = 32'h0;
                        err_d   = 1'b1;
                    end else if (we_q) begin
                        mem_wr  = 1'b1;
                        rdata_d = 32'h0;
                        err_d   = 1'b0;
                    end else begin
                        rdata_d = mem[idx];
                        err_d   = 1'b0;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                rdata_d = 32'h0;
                err_d   = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Captured request fields carry no reset; they are only consumed in WAIT.
    always_ff @(posedge clk) begin
        we_q    <= we_d;
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
`ifdef DMEM_BYTE_LANE_EN
        be_q    <= be_d;
`endif
    end

    // A reset landing on the access edge aborts the store as well.
    always_ff @(posedge clk) begin
        if (reset && mem_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_en[i]) begin
                    mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder
//   Directed bench for dmem_responder. Instance dut_a runs with LATENCY=0
//   and is driven from a vector table; instance dut_b runs with LATENCY=3
//   and covers held-request timing and reset-during-wait abort.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst_a, rst_b;
    logic        req_a, req_b;
    logic        we;
    logic [31:0] addr, wdata;
`ifdef DMEM_BYTE_LANE_EN
    logic [3:0]  be;
`endif
    logic [31:0] rdata_a, rdata_b;
    logic        ready_a, ready_b, err_a, err_b;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(64), .LATENCY(0)) dut_a (
        .clk   (clk),
        .reset (rst_a),
        .req   (req_a),
        .we    (we),
        .addr  (addr),
        .wdata (wdata),
`ifdef DMEM_BYTE_LANE_EN
        .be    (be),
`endif
        .rdata (rdata_a),
        .ready (ready_a),
        .err   (err_a)
    );

    dmem_responder #(.DEPTH(64), .LATENCY(3)) dut_b (
        .clk   (clk),
        .reset (rst_b),
        .req   (req_b),
        .we    (we),
        .addr  (addr),
        .wdata (wdata),
`ifdef DMEM_BYTE_LANE_EN
        .be    (be),
`endif
        .rdata (rdata_b),
        .ready (ready_b),
        .err   (err_b)
    );

    typedef struct {
        bit          w;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  b;
        logic [31:0] exp_rd;
        bit          exp_err;
        string       name;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Starts in IDLE at #1 after an edge; returns in IDLE at #1 after an edge.
    task automatic do_acc(input bit sel, input bit w, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] exp_rd,
                          input bit exp_err, input string name, input int lat);
        int cyc;
        we    = w;
        addr  = a;
        wdata = d;
        if (sel) req_b = 1'b1;
        else     req_a = 1'b1;
        @(posedge clk); #1;
        req_a = 1'b0;
        req_b = 1'b0;
        // Scramble inputs after accept; the DUT must use captured values.
        we    = ~w;
        addr  = ~a;
        wdata = ~d;
        cyc   = 1;
        while (!(sel ? ready_b : ready_a) && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk({name, "_latency"}, 32'(cyc), 32'(2 + lat));
        chk({name, "_rdata"}, sel ? rdata_b : rdata_a, exp_rd);
        chk({name, "_err"}, {31'h0, sel ? err_b : err_a}, {31'h0, exp_err});
        @(posedge clk); #1;
        chk({name, "_ready_drop"}, {31'h0, sel ? ready_b : ready_a}, 32'h0);
        chk({name, "_rdata_clr"}, sel ? rdata_b : rdata_a, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        rst_a = 1'b0;
        rst_b = 1'b0;
        req_a = 1'b0;
        req_b = 1'b0;
        we    = 1'b0;
        addr  = 32'h0;
        wdata = 32'h0;
`ifdef DMEM_BYTE_LANE_EN
        be    = 4'hF;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("rst_a_ready", {31'h0, ready_a}, 32'h0);
        chk("rst_a_err",   {31'h0, err_a},   32'h0);
        chk("rst_a_rdata", rdata_a,          32'h0);
        chk("rst_b_ready", {31'h0, ready_b}, 32'h0);
        chk("rst_b_err",   {31'h0, err_b},   32'h0);
        chk("rst_b_rdata", rdata_b,          32'h0);
        rst_a = 1'b1;
        rst_b = 1'b1;
        @(posedge clk); #1;

        vecs.push_back('{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0,         1'b0, "st_10"});
        vecs.push_back('{1'b0, 32'h0000_0010, 32'h0,         4'hF, 32'hDEAD_BEEF, 1'b0, "ld_10"});
        vecs.push_back('{1'b1, 32'h0000_0013, 32'h0000_0001, 4'hF, 32'h0,         1'b1, "st_misalign"});
        vecs.push_back('{1'b0, 32'h0000_0010, 32'h0,         4'hF, 32'hDEAD_BEEF, 1'b0, "ld_10_again"});
        vecs.push_back('{1'b0, 32'h0000_0100, 32'h0,         4'hF, 32'h0,         1'b1, "ld_oor"});
        vecs.push_back('{1'b1, 32'h0000_00FC, 32'h1234_5678, 4'hF, 32'h0,         1'b0, "st_fc"});
        vecs.push_back('{1'b0, 32'h0000_00FC, 32'h0,         4'hF, 32'h1234_5678, 1'b0, "ld_fc"});
        vecs.push_back('{1'b0, 32'h8000_0010, 32'h0,         4'hF, 32'h0,         1'b1, "ld_high_alias"});
        vecs.push_back('{1'b0, 32'h0000_0002, 32'h0,         4'hF, 32'h0,         1'b1, "ld_misalign"});
        vecs.push_back('{1'b1, 32'h0000_0008, 32'h1122_3344, 4'hF, 32'h0,         1'b0, "st_08"});
        vecs.push_back('{1'b0, 32'h0000_0008, 32'h0,         4'hF, 32'h1122_3344, 1'b0, "ld_08"});
`ifdef DMEM_BYTE_LANE_EN
        vecs.push_back('{1'b1, 32'h0000_0008, 32'hAABB_CCDD, 4'b0101, 32'h0,      1'b0, "st_08_be5"});
        vecs.push_back('{1'b0, 32'h0000_0008, 32'h0,         4'b0000, 32'h11BB_33DD, 1'b0, "ld_08_be5"});
        vecs.push_back('{1'b1, 32'h0000_0008, 32'hFFFF_FFFF, 4'b0000, 32'h0,      1'b0, "st_08_be0"});
        vecs.push_back('{1'b0, 32'h0000_0008, 32'h0,         4'b0000, 32'h11BB_33DD, 1'b0, "ld_08_be0"});
`endif

        foreach (vecs[i]) begin
`ifdef DMEM_BYTE_LANE_EN
            be = vecs[i].b;
`endif
            do_acc(1'b0, vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].exp_rd,
                   vecs[i].exp_err, vecs[i].name, 0);
        end
`ifdef DMEM_BYTE_LANE_EN
        be = 4'hF;
`endif

        // LATENCY=3 with req held: ready only in cycles 5 and 11.
        do_acc(1'b1, 1'b1, 32'h0, 32'h5A5A_0001, 32'h0, 1'b0, "b_st0", 3);
        we    = 1'b0;
        addr  = 32'h0;
        wdata = 32'h0;
        req_b = 1'b1;
        for (int c = 1; c <= 11; c++) begin
            @(posedge clk); #1;
            chk($sformatf("b_hold_ready_c%0d", c), {31'h0, ready_b},
                {31'h0, (c == 5 || c == 11)});
            if (c == 5)  chk("b_hold_rdata", rdata_b, 32'h5A5A_0001);
            if (c == 11) req_b = 1'b0;
        end
        @(posedge clk); #1;

        // Reset during WAIT of a store aborts it with no ready pulse.
        do_acc(1'b1, 1'b1, 32'h20, 32'hCAFE_F00D, 32'h0, 1'b0, "b_st20", 3);
        we    = 1'b1;
        addr  = 32'h20;
        wdata = 32'h0BAD_BEEF;
        req_b = 1'b1;
        @(posedge clk); #1;
        req_b = 1'b0;
        @(posedge clk); #1;
        rst_b = 1'b0;
        @(posedge clk); #1;
        rst_b = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            if (ready_b) seen = 1'b1;
            @(posedge clk); #1;
        end
        chk("b_abort_no_ready", {31'h0, seen}, 32'h0);
        do_acc(1'b1, 1'b0, 32'h20, 32'h0, 32'hCAFE_F00D, 1'b0, "b_ld20", 3);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
